// File: rtl/jtframe_pocket_dwnld_if.sv
// Bundle of APF bridge, byte-order/stall controls and ioctl download outputs
// shared between the download engine and its bridge-side master.
interface jtframe_pocket_dwnld_if #(
    parameter int AW = 24
);
    logic [31:0]   bridge_addr;
    logic          bridge_wr;
    logic [31:0]   bridge_wr_data;
    logic          bridge_rd;
    logic [31:0]   bridge_rd_data;
    logic          le;
    logic          dwnld_busy;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic [3:0]    ioctl_slot;
    logic          downloading;
    logic          overflow;

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd, le, dwnld_busy,
        output bridge_rd_data, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_slot,
               downloading, overflow
    );

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd, le, dwnld_busy,
        input  bridge_rd_data, ioctl_addr, ioctl_dout, ioctl_wr, ioctl_slot,
               downloading, overflow
    );
endinterface

// File: rtl/jtframe_pocket_dwnld.sv
// Pocket bridge-to-ioctl download engine: 32-bit bridge writes are queued in a
// FIFO and replayed as paced, stallable ioctl byte strobes across several slots.
module jtframe_pocket_dwnld #(
    parameter int SLOTS = 2,
    parameter int DEPTH = 8,
    parameter int AW    = 24,
    parameter int GAP   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    jtframe_pocket_dwnld_if.slave dwnld
);
    localparam int          PW         = $clog2(DEPTH);
    localparam int          EW         = 4 + (AW - 2) + 32;
    localparam int          GW         = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [31:0] CTRL_ADDR  = 32'hF000_0000;
    localparam logic [4:0]  SLOTS_W    = 5'(SLOTS);
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, DONE} state_t;
    state_t r_state, w_next;

    logic [EW-1:0]   r_fifo [DEPTH];
    logic [PW-1:0]   r_wptr, r_rptr;
    logic [PW:0]     r_count;
    logic [EW-1:0]   r_hold;
    logic [1:0]      r_idx;
    logic [GW-1:0]   r_gap;
    logic            r_downloading, r_overflow, r_end_pend;
    logic [31:0]     r_rd_data;
    logic [AW-1:0]   r_ioctl_addr;
    logic [7:0]      r_ioctl_dout;
    logic            r_ioctl_wr;
    logic [3:0]      r_ioctl_slot;

    logic            w_ctrl_wr, w_start, w_end, w_data_wr;
    logic            w_full, w_empty, w_pop, w_push, w_drop, w_strobe;
    logic [1:0]      w_sel;
    logic [31:0]     w_data;
    logic [7:0]      w_byte;

    always_comb begin
        w_ctrl_wr = dwnld.bridge_wr && (dwnld.bridge_addr == CTRL_ADDR);
        w_start   = w_ctrl_wr && dwnld.bridge_wr_data[0] && (r_state == IDLE);
        w_end     = w_ctrl_wr && !dwnld.bridge_wr_data[0];
        w_data_wr = dwnld.bridge_wr && (dwnld.bridge_addr[31:28] == 4'd0) &&
                    ({1'b0, dwnld.bridge_addr[27:24]} < SLOTS_W) && r_downloading;
        w_full    = (r_count == (PW+1)'(DEPTH));
        w_empty   = (r_count == '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
        w_push    = w_data_wr && (!w_full || w_pop);
        w_drop    = w_data_wr && w_full && !w_pop;
        w_sel     = dwnld.le ? r_idx : ~r_idx;
        w_data    = r_hold[31:0];
        w_byte    = w_data[{w_sel, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_pop    = 1'b0;
        w_strobe = 1'b0;
        case (r_state)
            IDLE: if (w_start) w_next = LOAD;
            LOAD: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_next = EMIT;
                end else if (r_end_pend) begin
                    w_next = DONE;
                end
            end
            EMIT: begin
                if (r_gap == '0 && !dwnld.dwnld_busy) begin
                    w_strobe = 1'b1;
                    if (r_idx == 2'd3) w_next = LOAD;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wptr] <= {dwnld.bridge_addr[27:24], dwnld.bridge_addr[AW-1:2],
                               dwnld.bridge_wr_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_hold        <= '0;
            r_idx         <= '0;
            r_gap         <= '0;
            r_downloading <= 1'b0;
            r_overflow    <= 1'b0;
            r_end_pend    <= 1'b0;
            r_rd_data     <= '0;
            r_ioctl_addr  <= '0;
            r_ioctl_dout  <= '0;
            r_ioctl_wr    <= 1'b0;
            r_ioctl_slot  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_hold <= r_fifo[r_rptr];
                r_rptr <= r_rptr + 1'b1;
                r_idx  <= '0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase

            if (w_strobe)          r_gap <= GAP_LOAD;
            else if (r_gap != '0)  r_gap <= r_gap - 1'b1;

            r_ioctl_wr <= w_strobe;
            if (w_strobe) begin
                r_idx        <= r_idx + 1'b1;
                r_ioctl_addr <= {r_hold[EW-5 -: AW-2], r_idx};
                r_ioctl_dout <= w_byte;
                r_ioctl_slot <= r_hold[EW-1 -: 4];
            end

            if (w_start) begin
                r_downloading <= 1'b1;
                r_overflow    <= 1'b0;
            end else if (r_state == DONE) begin
                r_downloading <= 1'b0;
            end
            if (w_drop) r_overflow <= 1'b1;

            if (r_state == DONE)              r_end_pend <= 1'b0;
            else if (w_end && r_downloading)  r_end_pend <= 1'b1;

            if (dwnld.bridge_rd && dwnld.bridge_addr == CTRL_ADDR)
                r_rd_data <= {r_downloading, r_overflow, r_state != IDLE, 13'd0,
                              r_ioctl_slot, 12'd0};
            else
                r_rd_data <= '0;
        end
    end

    assign dwnld.bridge_rd_data = r_rd_data;
    assign dwnld.ioctl_addr     = r_ioctl_addr;
    assign dwnld.ioctl_dout     = r_ioctl_dout;
    assign dwnld.ioctl_wr       = r_ioctl_wr;
    assign dwnld.ioctl_slot     = r_ioctl_slot;
    assign dwnld.downloading    = r_downloading;
    assign dwnld.overflow       = r_overflow;
endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Bench for jtframe_pocket_dwnld: vector table, hand-written corner sequences and
// randomized sessions compared against a byte-level expectation queue.
module tb_jtframe_pocket_dwnld;
    localparam int SLOTS = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 24;
    localparam int GAP   = 2;
    localparam logic [31:0] CTRL = 32'hF000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    jtframe_pocket_dwnld_if #(.AW(AW)) bus ();

    jtframe_pocket_dwnld #(
        .SLOTS (SLOTS),
        .DEPTH (DEPTH),
        .AW    (AW),
        .GAP   (GAP)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .dwnld (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int push_cyc = 0;
    int last_strobe = -1000;
    int busy_mode = 0;
    logic busy_force = 1'b0;
    logic [35:0] obs[$];
    int obs_cyc[$];
    logic [35:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        le;
        logic [23:0] base;
        logic [3:0]  slot;
        logic [31:0] bytes_exp;   // emission order, first byte in [31:24]
    } vec_t;
    vec_t vt[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (bus.ioctl_wr === 1'b1) begin
            obs.push_back({bus.ioctl_slot, bus.ioctl_addr, bus.ioctl_dout});
            obs_cyc.push_back(cyc);
            check("strobe_spacing", (cyc - last_strobe >= GAP) ? 64'd1 : 64'd0, 64'd1);
            last_strobe = cyc;
        end
    end

    initial begin
        int ph = 0;
        bus.dwnld_busy = 1'b0;
        forever begin
            @(negedge clk);
            ph++;
            case (busy_mode)
                1:       bus.dwnld_busy = 1'($urandom_range(0, 1));
                2:       if (ph % 3 == 0) bus.dwnld_busy = ~bus.dwnld_busy;
                default: bus.dwnld_busy = busy_force;
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wr_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.bridge_addr    = a;
        bus.bridge_wr_data = d;
        bus.bridge_wr      = 1'b1;
        @(posedge clk);
        #1 push_cyc = cyc;
        @(negedge clk);
        bus.bridge_wr = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] aq[$], input logic [31:0] dq[$]);
        foreach (aq[i]) begin
            @(negedge clk);
            bus.bridge_addr    = aq[i];
            bus.bridge_wr_data = dq[i];
            bus.bridge_wr      = 1'b1;
        end
        @(negedge clk);
        bus.bridge_wr = 1'b0;
    endtask

    task automatic ctrl(input logic v);
        wr_word(CTRL, {31'd0, v});
    endtask

    task automatic read_status(input logic [31:0] a, output logic [31:0] v);
        @(negedge clk);
        bus.bridge_addr = a;
        bus.bridge_rd   = 1'b1;
        @(negedge clk);
        v = bus.bridge_rd_data;
        bus.bridge_rd = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int k = 0;
        while (obs.size() < n && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        check(name, (obs.size() >= n) ? 64'd1 : 64'd0, 64'd1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (bus.downloading !== 1'b0 && k < budget) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("idle_timeout", bus.downloading, 0);
    endtask

    // Expected byte stream of one accepted word, straight from the byte-order rule
    function automatic void model_word(input logic [31:0] a, input logic [31:0] d, input logic le_v);
        logic [23:0] base;
        base = {a[23:2], 2'b00};
        for (int k = 0; k < 4; k++) begin
            int sh;
            sh = le_v ? 8 * k : 8 * (3 - k);
            exp_q.push_back({a[27:24], base + 24'(k), 8'(d >> sh)});
        end
    endfunction

    function automatic logic accepted(input logic [31:0] a);
        return (a[31:28] == 4'd0) && (int'(a[27:24]) < SLOTS);
    endfunction

    task automatic compare_all(input string tag);
        check({tag, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            check({tag, "_byte"}, obs[i], exp_q[i]);
        obs.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] st;
        logic [31:0] bx;
        logic [31:0] aq[$];
        logic [31:0] dq[$];
        int fall;

        bus.bridge_addr    = '0;
        bus.bridge_wr      = 1'b0;
        bus.bridge_wr_data = '0;
        bus.bridge_rd      = 1'b0;
        bus.le             = 1'b0;

        vt[0] = '{32'h0000_0100, 32'h1122_3344, 1'b0, 24'h000100, 4'h0, 32'h1122_3344};
        vt[1] = '{32'h0100_0010, 32'hAABB_CCDD, 1'b1, 24'h000010, 4'h1, 32'hDDCC_BBAA};
        vt[2] = '{32'h0000_0107, 32'h0102_0304, 1'b0, 24'h000104, 4'h0, 32'h0102_0304};
        vt[3] = '{32'h01FF_FFFC, 32'hCAFE_F00D, 1'b1, 24'hFFFFFC, 4'h1, 32'h0DF0_FECA};
        vt[4] = '{32'h0000_0000, 32'h8000_0001, 1'b0, 24'h000000, 4'h0, 32'h8000_0001};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {bus.ioctl_addr, bus.ioctl_dout, bus.ioctl_wr, bus.ioctl_slot,
                                bus.downloading, bus.overflow}, 0);
        check("reset_rd_data", bus.bridge_rd_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            bus.le = vt[i].le;
            ctrl(1'b1);
            wr_word(vt[i].addr, vt[i].data);
            fall = push_cyc;
            ctrl(1'b0);
            wait_strobes(4, 50, "vec_timeout");
            if (obs.size() >= 4) begin
                bx = vt[i].bytes_exp;
                for (int k = 0; k < 4; k++)
                    check("vec_byte", obs[k], {vt[i].slot, vt[i].base + 24'(k), bx[31-8*k -: 8]});
                check("vec_latency", obs_cyc[0] - fall, 2);
                check("vec_gap", obs_cyc[3] - obs_cyc[2], GAP);
                fall = -1;
                for (int w = 0; w < 20 && fall < 0; w++) begin
                    @(posedge clk);
                    #2;
                    if (bus.downloading === 1'b0) fall = cyc;
                end
                check("vec_dl_fall", fall - obs_cyc[3], 2);
            end
            wait_idle(50);
            check("vec_extra_strobes", obs.size(), 4);
            obs.delete();
            obs_cyc.delete();
        end

        // Overflow: held word plus DEPTH queued words survive, the last write is dropped
        bus.le = 1'b0;
        busy_force = 1'b1;
        ctrl(1'b1);
        aq.delete();
        dq.delete();
        for (int i = 0; i < DEPTH + 2; i++) begin
            aq.push_back(32'h0000_1000 + 32'(4 * i));
            dq.push_back($urandom);
            if (i < DEPTH + 1) model_word(aq[i], dq[i], 1'b0);
        end
        wr_burst(aq, dq);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_no_strobe_while_busy", obs.size(), 0);
        read_status(CTRL, st);
        check("ovf_status_bits", st[31:29], 3'b111);
        busy_force = 1'b0;
        wait_strobes(4 * (DEPTH + 1), 200, "ovf_timeout");
        repeat (10) @(posedge clk);
        compare_all("ovf");
        ctrl(1'b0);
        wait_idle(50);
        check("ovf_sticky", bus.overflow, 1);
        ctrl(1'b1);
        check("ovf_cleared_by_start", bus.overflow, 0);

        // Invalid writes inside and outside a session
        wr_word({4'h0, 4'h2, 24'h000300}, 32'hDEAD_BEEF);
        wr_word({4'h3, 28'h0000400}, 32'h1234_5678);
        read_status(32'h0000_0100, st);
        check("rd_other_addr", st, 0);
        read_status(CTRL, st);
        check("inv_status_bits", st[31:29], 3'b101);
        ctrl(1'b0);
        wait_idle(50);
        wr_word(32'h0000_0500, 32'h0BAD_F00D);
        repeat (10) @(posedge clk);
        check("inv_no_strobe", obs.size(), 0);
        read_status(CTRL, st);
        check("idle_status_bits", st[31:29], 3'b000);

        // Back-pressure: busy toggles every 3 cycles through a 4-word burst
        busy_mode = 2;
        ctrl(1'b1);
        aq.delete();
        dq.delete();
        for (int i = 0; i < 4; i++) begin
            aq.push_back(32'h0000_0200 + 32'(4 * i));
            dq.push_back($urandom);
            model_word(aq[i], dq[i], 1'b0);
        end
        wr_burst(aq, dq);
        ctrl(1'b0);
        wait_strobes(16, 300, "bp_timeout");
        wait_idle(50);
        compare_all("bp");
        busy_mode = 0;

        // Randomized sessions with random stalls, byte order and invalid writes
        busy_mode = 1;
        for (int s = 0; s < 6; s++) begin
            logic lev;
            lev = 1'($urandom_range(0, 1));
            bus.le = lev;
            ctrl(1'b1);
            for (int b = 0; b < 3; b++) begin
                int n;
                n = $urandom_range(1, DEPTH);
                aq.delete();
                dq.delete();
                for (int j = 0; j < n; j++) begin
                    logic [31:0] a;
                    logic [31:0] d;
                    case ($urandom_range(0, 5))
                        0:       a = {4'($urandom_range(1, 14)), 28'($urandom)};
                        1:       a = {4'h0, 4'($urandom_range(SLOTS, 15)), 24'($urandom)};
                        default: a = {4'h0, 4'($urandom_range(0, SLOTS - 1)), 24'($urandom)};
                    endcase
                    d = $urandom;
                    aq.push_back(a);
                    dq.push_back(d);
                    if (accepted(a)) model_word(a, d, lev);
                end
                wr_burst(aq, dq);
                wait_strobes(exp_q.size(), 400, "rand_timeout");
            end
            ctrl(1'b0);
            wait_idle(400);
            compare_all("rand");
        end
        busy_mode = 0;

        // Reset between byte 1 and byte 2
        bus.le = 1'b0;
        ctrl(1'b1);
        wr_word(32'h0100_0020, 32'h5566_7788);
        wait_strobes(1, 20, "rst_timeout");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_outputs", {bus.ioctl_addr, bus.ioctl_dout, bus.ioctl_wr, bus.ioctl_slot,
                              bus.downloading, bus.overflow}, 0);
        check("rst_rd_data", bus.bridge_rd_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        check("rst_no_more_strobes", obs.size(), 1);
        if (obs.size() >= 1) check("rst_first_byte", obs[0], {4'h1, 24'h000020, 8'h55});
        read_status(CTRL, st);
        check("rst_status", st, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
